// File: rtl/mem_arb2.sv
// Two-client arbiter in front of a single-outstanding delayed memory; one pending slot per client.
// Arbitration is fixed priority (port 0 wins) unless MEM_ARB_RR_EN is defined, which selects round-robin.
module mem_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_c0_rd_req,
  input  logic              i_c0_wr_req,
  input  logic [ADDR_W-1:0] i_c0_addr,
  input  logic [DATA_W-1:0] i_c0_wr_data,
  output logic              o_c0_busy,
  output logic              o_c0_ack,
  output logic [DATA_W-1:0] o_c0_rd_data,
  input  logic              i_c1_rd_req,
  input  logic              i_c1_wr_req,
  input  logic [ADDR_W-1:0] i_c1_addr,
  input  logic [DATA_W-1:0] i_c1_wr_data,
  output logic              o_c1_busy,
  output logic              o_c1_ack,
  output logic [DATA_W-1:0] o_c1_rd_data,
  output logic              o_mem_rd_req,
  output logic              o_mem_wr_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wr_data,
  input  logic              i_mem_busy,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  output logic              o_gnt
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t            r_state;
  logic              r_gnt;
  logic [1:0]        r_pend;
  logic [1:0]        r_pend_wr;
  logic [ADDR_W-1:0] r_pend_addr [2];
  logic [DATA_W-1:0] r_pend_data [2];
  logic [1:0]        r_ack;
  logic [DATA_W-1:0] r_rd_data [2];
  logic              r_mem_rd_req;
  logic              r_mem_wr_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wr_data;

  logic [1:0]        w_rd_req;
  logic [1:0]        w_wr_req;
  logic [ADDR_W-1:0] w_addr [2];
  logic [DATA_W-1:0] w_wr_data [2];
  logic              w_done;
  logic [1:0]        w_cpl;
  logic [1:0]        w_accept;
  logic              w_start;
  logic              w_win;

  assign w_rd_req     = {i_c1_rd_req, i_c0_rd_req};
  assign w_wr_req     = {i_c1_wr_req, i_c0_wr_req};
  assign w_addr[0]    = i_c0_addr;
  assign w_addr[1]    = i_c1_addr;
  assign w_wr_data[0] = i_c0_wr_data;
  assign w_wr_data[1] = i_c1_wr_data;

  assign w_done   = (r_state == S_WAIT) && i_mem_ack;
  assign w_cpl    = {w_done & r_gnt, w_done & ~r_gnt};
  // A slot completing this edge may be refilled on the same edge.
  assign w_accept = (w_rd_req | w_wr_req) & (~r_pend | w_cpl);
  assign w_start  = (r_state == S_IDLE) && (|r_pend) && !i_mem_busy;

`ifdef MEM_ARB_RR_EN
  logic r_ptr;

  assign w_win = (&r_pend) ? r_ptr : r_pend[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_start) begin
      r_ptr <= ~w_win;
    end
  end
`else
  assign w_win = ~r_pend[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend    <= '0;
      r_pend_wr <= '0;
      for (int n = 0; n < 2; n++) begin
        r_pend_addr[n] <= '0;
        r_pend_data[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_accept[n]) begin
          r_pend[n]      <= 1'b1;
          r_pend_wr[n]   <= w_wr_req[n];
          r_pend_addr[n] <= w_addr[n];
          r_pend_data[n] <= w_wr_data[n];
        end else if (w_cpl[n]) begin
          r_pend[n] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_gnt         <= 1'b0;
      r_ack         <= '0;
      r_rd_data[0]  <= '0;
      r_rd_data[1]  <= '0;
      r_mem_rd_req  <= 1'b0;
      r_mem_wr_req  <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
    end else begin
      r_mem_rd_req <= 1'b0;
      r_mem_wr_req <= 1'b0;
      r_ack        <= '0;
      r_rd_data[0] <= '0;
      r_rd_data[1] <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state       <= S_WAIT;
            r_gnt         <= w_win;
            r_mem_rd_req  <= ~r_pend_wr[w_win];
            r_mem_wr_req  <= r_pend_wr[w_win];
            r_mem_addr    <= r_pend_addr[w_win];
            r_mem_wr_data <= r_pend_data[w_win];
          end
        end
        S_WAIT: begin
          if (i_mem_ack) begin
            r_state          <= S_IDLE;
            r_ack[r_gnt]     <= 1'b1;
            r_rd_data[r_gnt] <= r_pend_wr[r_gnt] ? '0 : i_mem_rd_data;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_c0_busy     = r_pend[0];
  assign o_c1_busy     = r_pend[1];
  assign o_c0_ack      = r_ack[0];
  assign o_c1_ack      = r_ack[1];
  assign o_c0_rd_data  = r_rd_data[0];
  assign o_c1_rd_data  = r_rd_data[1];
  assign o_mem_rd_req  = r_mem_rd_req;
  assign o_mem_wr_req  = r_mem_wr_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wr_data = r_mem_wr_data;
  assign o_gnt         = r_gnt;

endmodule
